// File: rtl/pcg_noise_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pcg_noise_pkg                                                            |
// | Shared types and default generator constants for the PCG noise injector.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pcg_noise_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_CONT   = 2'b01,
        MODE_BURST  = 2'b10,
        MODE_SPARSE = 2'b11
    } mode_e;

    typedef enum logic {
        BURST_IDLE   = 1'b0,
        BURST_ACTIVE = 1'b1
    } burst_state_e;

    localparam int unsigned c_mult_default     = 12829;
    localparam int unsigned c_inc_default      = 47989;
    localparam int unsigned c_out_mult_default = 62169;
    localparam int unsigned c_seed_default     = 4356;

endpackage
`default_nettype wire

// File: rtl/pcg_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pcg_gen                                                                  |
// | LCG state register with an xorshift-multiply output permutation.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pcg_gen
    import pcg_noise_pkg::*;
#(
    parameter int unsigned STATE_W  = 16,
    parameter int unsigned NOISE_W  = 8,
    parameter int unsigned MULT     = c_mult_default,
    parameter int unsigned INC      = c_inc_default,
    parameter int unsigned OUT_MULT = c_out_mult_default,
    parameter int unsigned SEED     = c_seed_default
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_load,
    input  logic [STATE_W-1:0] seed_data,
    output logic [NOISE_W-1:0] noise
);

    localparam logic [STATE_W-1:0] c_mult     = STATE_W'(MULT);
    localparam logic [STATE_W-1:0] c_inc      = STATE_W'(INC);
    localparam logic [STATE_W-1:0] c_out_mult = STATE_W'(OUT_MULT);
    localparam logic [STATE_W-1:0] c_seed     = STATE_W'(SEED);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [NOISE_W-1:0] noise_q;
    logic [NOISE_W-1:0] noise_d;
    logic [STATE_W-1:0] lcg_next;
    logic [STATE_W-1:0] mixed;
    logic [STATE_W-1:0] permuted;
    logic [3:0]         shift_amt;

    // The output is permuted from the current state, so noise trails state by one edge.
    always_comb begin
        lcg_next  = state_q * c_mult + c_inc;
        shift_amt = {1'b0, state_q[STATE_W-1 -: 3]} + 4'd3;
        mixed     = (state_q >> shift_amt) ^ state_q;
        permuted  = mixed * c_out_mult;
        state_d   = lcg_next;
        noise_d   = NOISE_W'(permuted >> (STATE_W - NOISE_W));
        if (seed_load) begin
            state_d = seed_data;
            noise_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_seed;
            noise_q <= '0;
        end else begin
            state_q <= state_d;
            noise_q <= noise_d;
        end
    end

    assign noise = noise_q;

endmodule
`default_nettype wire

// File: rtl/pcg_noise_injector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pcg_noise_injector                                                       |
// | Mode-gated, masked PCG noise XORed onto a registered pass-through bus.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pcg_noise_injector
    import pcg_noise_pkg::*;
#(
    parameter int unsigned STATE_W  = 16,
    parameter int unsigned NOISE_W  = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BURST_W  = 8,
    parameter int unsigned MULT     = c_mult_default,
    parameter int unsigned INC      = c_inc_default,
    parameter int unsigned OUT_MULT = c_out_mult_default,
    parameter int unsigned SEED     = c_seed_default
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               trigger,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               seed_valid,
    input  logic [STATE_W-1:0] seed_data,
    output logic               seed_ready,
    input  logic [DATA_W-1:0]  mask,
    input  logic [DATA_W-1:0]  din,
    output logic [DATA_W-1:0]  dout,
    output logic [NOISE_W-1:0] noise,
    output logic               busy
);

    burst_state_e       bstate_q;
    burst_state_e       bstate_d;
    logic [BURST_W-1:0] burst_cnt_q;
    logic [BURST_W-1:0] burst_cnt_d;
    logic [DATA_W-1:0]  dout_q;
    logic [DATA_W-1:0]  dout_d;
    logic [DATA_W-1:0]  nbit;
    logic [NOISE_W-1:0] noise_w;
    mode_e              mode_w;
    logic               gate;
    logic               seed_accept;
    logic               burst_mode;
    logic               len_zero;

    assign mode_w      = mode_e'(mode);
    assign burst_mode  = (mode_w == MODE_BURST);
    assign len_zero    = (burst_len == '0);
    assign busy        = (bstate_q == BURST_ACTIVE);
    assign seed_ready  = ~busy;
    assign seed_accept = seed_valid & seed_ready;

    pcg_gen #(
        .STATE_W  (STATE_W),
        .NOISE_W  (NOISE_W),
        .MULT     (MULT),
        .INC      (INC),
        .OUT_MULT (OUT_MULT),
        .SEED     (SEED)
    ) u_gen (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_accept),
        .seed_data (seed_data),
        .noise     (noise_w)
    );

    // Replicate the noise word across the data bus when DATA_W exceeds NOISE_W.
    generate
        for (genvar i = 0; i < DATA_W; i++) begin : g_spread
            assign nbit[i] = noise_w[i % NOISE_W];
        end
    endgenerate

    always_comb begin
        bstate_d    = bstate_q;
        burst_cnt_d = burst_cnt_q;
        case (bstate_q)
            BURST_IDLE: begin
                if (burst_mode && trigger && !len_zero) begin
                    bstate_d    = BURST_ACTIVE;
                    burst_cnt_d = burst_len;
                end
            end
            BURST_ACTIVE: begin
                // Leaving BURST mode or retriggering with a zero length aborts the burst.
                if (!burst_mode || (trigger && len_zero)) begin
                    bstate_d    = BURST_IDLE;
                    burst_cnt_d = '0;
                end else if (trigger) begin
                    burst_cnt_d = burst_len;
                end else if (burst_cnt_q == BURST_W'(1)) begin
                    bstate_d    = BURST_IDLE;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q - BURST_W'(1);
                end
            end
            default: begin
                bstate_d    = BURST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        gate = 1'b0;
        case (mode_w)
            MODE_OFF:    gate = 1'b0;
            MODE_CONT:   gate = 1'b1;
            MODE_BURST:  gate = busy;
            MODE_SPARSE: gate = (noise_w[NOISE_W-1 -: 2] == 2'b11);
            default:     gate = 1'b0;
        endcase
        dout_d = din ^ (nbit & mask & {DATA_W{gate}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bstate_q    <= BURST_IDLE;
            burst_cnt_q <= '0;
            dout_q      <= '0;
        end else begin
            bstate_q    <= bstate_d;
            burst_cnt_q <= burst_cnt_d;
            dout_q      <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign noise = noise_w;

endmodule
`default_nettype wire

// File: tb/tb_pcg_noise_injector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pcg_noise_injector                                                    |
// | Scoreboard bench for the noise injector with default parameters.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pcg_noise_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        trigger;
    logic [7:0]  burst_len;
    logic        seed_valid;
    logic [15:0] seed_data;
    logic        seed_ready;
    logic [7:0]  mask;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [7:0]  noise;
    logic        busy;

    always #5 clk = ~clk;

    pcg_noise_injector #(
        .STATE_W(16), .NOISE_W(8), .DATA_W(8), .BURST_W(8),
        .MULT(12829), .INC(47989), .OUT_MULT(62169), .SEED(4356)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .trigger(trigger), .burst_len(burst_len),
        .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
        .mask(mask), .din(din), .dout(dout), .noise(noise), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] dout;
        logic [7:0] noise;
        logic       busy;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_state;
    logic [7:0]  m_noise;
    logic        m_busy;
    int          m_cnt;
    int          m_gated;
    logic [7:0]  ref_seq [8];

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        int unsigned t;
        t = int'(s) * 12829 + 47989;
        return t[15:0];
    endfunction

    function automatic logic [7:0] ref_noise(input logic [15:0] s);
        int unsigned sh, x, p;
        sh = int'(s[15:13]) + 3;
        x  = (int'(s) >> sh) ^ int'(s);
        p  = x * 62169;
        return p[15:8];
    endfunction

    task automatic model_reset();
        m_state = 16'd4356;
        m_noise = 8'h00;
        m_busy  = 1'b0;
        m_cnt   = 0;
        sb.delete();
    endtask

    // Predict the effect of the next edge from current inputs, then advance one clock.
    task automatic cycle();
        exp_t e;
        logic acc;
        logic g;
        acc = seed_valid && !m_busy;
        case (mode)
            2'b00:   g = 1'b0;
            2'b01:   g = 1'b1;
            2'b10:   g = m_busy;
            default: g = (m_noise[7:6] == 2'b11);
        endcase
        if (g) m_gated++;
        e.dout  = din ^ (m_noise & mask & {8{g}});
        e.noise = acc ? 8'h00 : ref_noise(m_state);
        m_state = acc ? seed_data : ref_next(m_state);
        if (!m_busy) begin
            if (mode == 2'b10 && trigger && burst_len != 0) begin
                m_busy = 1'b1;
                m_cnt  = burst_len;
            end
        end else if (mode != 2'b10 || (trigger && burst_len == 0)) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (trigger) begin
            m_cnt = burst_len;
        end else if (m_cnt == 1) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else begin
            m_cnt--;
        end
        e.busy  = m_busy;
        m_noise = e.noise;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'b00; trigger = 1'b0; burst_len = 8'd0;
        seed_valid = 1'b0; seed_data = 16'd0; mask = 8'h00; din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else n_pass++;
        n_checks++; if (noise !== 8'h00) $display("FAIL reset_noise: got %h expected 00", noise); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (seed_ready !== 1'b1) $display("FAIL reset_seed_ready: got %b expected 1", seed_ready); else n_pass++;
        n_checks++; if (dut.u_gen.state_q !== 16'd4356) $display("FAIL reset_state: got %0d expected 4356", dut.u_gen.state_q); else n_pass++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_cont_first();
        exp_t e;
        mode = 2'b01; mask = 8'hFF; din = 8'h00;
        cycle();
        e = sb.pop_front();
        ref_seq[0] = e.noise;
        n_checks++; if (dut.u_gen.state_q !== 16'd28905) $display("FAIL cont_state1: got %0d expected 28905", dut.u_gen.state_q); else n_pass++;
        n_checks++; if (noise !== 8'h41) $display("FAIL cont_noise1: got %h expected 41", noise); else n_pass++;
        cycle();
        e = sb.pop_front();
        ref_seq[1] = e.noise;
        n_checks++; if (dout !== 8'h41) $display("FAIL cont_dout2: got %h expected 41", dout); else n_pass++;
        for (int k = 2; k < 8; k++) begin
            din = 8'($urandom);
            cycle();
            e = sb.pop_front();
            ref_seq[k] = e.noise;
            n_checks++;
            if ({dout, noise, busy} !== {e.dout, e.noise, e.busy})
                $display("FAIL cont_sb: got %h/%h/%b expected %h/%h/%b", dout, noise, busy, e.dout, e.noise, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_off();
        exp_t e;
        mode = 2'b00; din = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            mask = 8'($urandom);
            cycle();
            e = sb.pop_front();
            n_checks++; if (dout !== 8'hA5) $display("FAIL off_dout: got %h expected a5", dout); else n_pass++;
            n_checks++;
            if ({dout, noise, busy} !== {e.dout, e.noise, e.busy})
                $display("FAIL off_sb: got %h/%h/%b expected %h/%h/%b", dout, noise, busy, e.dout, e.noise, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_burst();
        exp_t e;
        int   nbusy;
        mode = 2'b10; mask = 8'hFF;
        // Single burst, then a burst retriggered after two busy cycles, then a zero-length trigger.
        for (int run = 0; run < 3; run++) begin
            nbusy = 0;
            for (int k = 0; k < 12; k++) begin
                trigger   = (k == 0) || (run == 1 && k == 2);
                burst_len = (run == 2) ? 8'd0 : 8'd5;
                din       = 8'($urandom);
                cycle();
                e = sb.pop_front();
                if (busy === 1'b1) nbusy++;
                n_checks++;
                if ({dout, noise, busy} !== {e.dout, e.noise, e.busy})
                    $display("FAIL burst_sb: got %h/%h/%b expected %h/%h/%b", dout, noise, busy, e.dout, e.noise, e.busy);
                else n_pass++;
            end
            trigger = 1'b0;
            n_checks++;
            if (nbusy !== ((run == 0) ? 5 : (run == 1) ? 7 : 0))
                $display("FAIL burst_len_run%0d: got %0d busy cycles expected %0d", run, nbusy, (run == 0) ? 5 : (run == 1) ? 7 : 0);
            else n_pass++;
        end
        // Abort by retrigger with zero length, then abort by leaving BURST mode.
        for (int run = 0; run < 2; run++) begin
            trigger = 1'b1; burst_len = 8'd10;
            cycle(); void'(sb.pop_front());
            trigger = 1'b0;
            cycle(); void'(sb.pop_front());
            if (run == 0) begin trigger = 1'b1; burst_len = 8'd0; end
            else mode = 2'b01;
            cycle();
            e = sb.pop_front();
            trigger = 1'b0;
            n_checks++; if (busy !== 1'b0) $display("FAIL burst_abort%0d: got busy %b expected 0", run, busy); else n_pass++;
            n_checks++;
            if ({dout, noise, busy} !== {e.dout, e.noise, e.busy})
                $display("FAIL burst_abort_sb: got %h/%h/%b expected %h/%h/%b", dout, noise, busy, e.dout, e.noise, e.busy);
            else n_pass++;
            mode = 2'b10;
        end
    endtask

    task automatic test_seed();
        exp_t e;
        mode = 2'b01; mask = 8'hFF;
        for (int k = 0; k < 3; k++) begin din = 8'($urandom); cycle(); void'(sb.pop_front()); end
        seed_valid = 1'b1; seed_data = 16'd4356;
        cycle();
        seed_valid = 1'b0;
        e = sb.pop_front();
        n_checks++; if (noise !== 8'h00) $display("FAIL seed_noise0: got %h expected 00", noise); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            din = 8'($urandom);
            cycle();
            e = sb.pop_front();
            n_checks++; if (noise !== ref_seq[k]) $display("FAIL seed_replay%0d: got %h expected %h", k, noise, ref_seq[k]); else n_pass++;
            n_checks++;
            if ({dout, noise, busy} !== {e.dout, e.noise, e.busy})
                $display("FAIL seed_sb: got %h/%h/%b expected %h/%h/%b", dout, noise, busy, e.dout, e.noise, e.busy);
            else n_pass++;
        end
        // Seed request while a burst runs must be ignored.
        mode = 2'b10; trigger = 1'b1; burst_len = 8'd20;
        cycle(); void'(sb.pop_front());
        trigger = 1'b0; seed_valid = 1'b1; seed_data = 16'h1234;
        n_checks++; if (seed_ready !== 1'b0) $display("FAIL seed_ready_busy: got %b expected 0", seed_ready); else n_pass++;
        cycle();
        seed_valid = 1'b0;
        e = sb.pop_front();
        n_checks++; if (dut.u_gen.state_q !== m_state) $display("FAIL seed_ignored_state: got %h expected %h", dut.u_gen.state_q, m_state); else n_pass++;
        n_checks++;
        if ({dout, noise, busy} !== {e.dout, e.noise, e.busy})
            $display("FAIL seed_busy_sb: got %h/%h/%b expected %h/%h/%b", dout, noise, busy, e.dout, e.noise, e.busy);
        else n_pass++;
        mode = 2'b00;
        cycle(); void'(sb.pop_front());
        // Seed and trigger together while idle both land on the same edge.
        mode = 2'b10; seed_valid = 1'b1; seed_data = 16'd4356; trigger = 1'b1; burst_len = 8'd3;
        cycle();
        seed_valid = 1'b0; trigger = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if ({noise, busy} !== {8'h00, 1'b1}) $display("FAIL seed_and_trigger: got %h/%b expected 00/1", noise, busy);
        else n_pass++;
        n_checks++;
        if ({dout, noise, busy} !== {e.dout, e.noise, e.busy})
            $display("FAIL seed_trig_sb: got %h/%h/%b expected %h/%h/%b", dout, noise, busy, e.dout, e.noise, e.busy);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin cycle(); void'(sb.pop_front()); end
    endtask

    task automatic test_sparse();
        exp_t e;
        int   dut_gated;
        mode = 2'b11; mask = 8'h0F; m_gated = 0; dut_gated = 0;
        for (int k = 0; k < 10000; k++) begin
            din = 8'($urandom);
            if (noise[7:6] == 2'b11) dut_gated++;
            cycle();
            e = sb.pop_front();
            n_checks++; if (dout[7:4] !== din[7:4]) $display("FAIL sparse_upper: got %h expected %h", dout[7:4], din[7:4]); else n_pass++;
            n_checks++;
            if ({dout, noise, busy} !== {e.dout, e.noise, e.busy})
                $display("FAIL sparse_sb: got %h/%h/%b expected %h/%h/%b", dout, noise, busy, e.dout, e.noise, e.busy);
            else n_pass++;
        end
        n_checks++; if (dut_gated !== m_gated) $display("FAIL sparse_gate_count: got %0d expected %0d", dut_gated, m_gated); else n_pass++;
        n_checks++;
        if (dut_gated < 2300 || dut_gated > 2700) $display("FAIL sparse_fraction: got %0d of 10000 expected 2300..2700", dut_gated);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        exp_t e;
        mode = 2'b10; mask = 8'hFF; trigger = 1'b1; burst_len = 8'd50; din = 8'h00;
        cycle(); void'(sb.pop_front());
        trigger = 1'b0;
        for (int k = 0; k < 3; k++) begin cycle(); void'(sb.pop_front()); end
        n_checks++; if (busy !== 1'b1) $display("FAIL areset_pre_busy: got %b expected 1", busy); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (dout !== 8'h00) $display("FAIL areset_dout: got %h expected 00", dout); else n_pass++;
        n_checks++; if (noise !== 8'h00) $display("FAIL areset_noise: got %h expected 00", noise); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b expected 0", busy); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (dut.u_gen.state_q !== 16'd4356) $display("FAIL areset_state: got %0d expected 4356", dut.u_gen.state_q); else n_pass++;
        model_reset();
        mode = 2'b01; din = 8'h00;
        cycle();
        e = sb.pop_front();
        n_checks++; if (noise !== 8'h41) $display("FAIL areset_noise1: got %h expected 41", noise); else n_pass++;
        n_checks++;
        if ({dout, noise, busy} !== {e.dout, e.noise, e.busy})
            $display("FAIL areset_sb: got %h/%h/%b expected %h/%h/%b", dout, noise, busy, e.dout, e.noise, e.busy);
        else n_pass++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cont_first();
        test_off();
        test_burst();
        test_seed();
        test_sparse();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
